// File: rtl/multi_tap_delay_line.sv
// multi_tap_delay_line
//   N-tap delay line for the coil gate-drive feedback path. The 1-bit input
//   is shifted through DEPTH stages; each of NUM_TAPS outputs picks one stage.
//   New tap delays are accepted via a valid/ready handshake into a shadow
//   register. They become active on the next rising edge entering the line,
//   or after COMMIT_TIMEOUT cycles, whichever comes first.
//
//   Optional build macro: DELAY_LINE_FILTER_EN enables an input deglitch
//   filter of FILTER_LEN edges in front of the line.
//
// Ports
//   clock        in   single clock domain
//   reset        in   synchronous, active-high
//   in           in   signal to delay
//   phase_data   in   packed tap delays, tap i at [i*PHASE_W +: PHASE_W]
//   phase_valid  in   phase_data valid
//   phase_ready  out  block can accept phase_data
//   tap_enable   in   per-tap enable, a disabled tap drives 0
//   out          out  delayed taps (registered)
//   phase_err    out  sticky: a received delay was >= DEPTH
//   committed    out  one-cycle pulse when staged delays become active
module multi_tap_delay_line #(
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned NUM_TAPS       = 4,
  parameter int unsigned PHASE_W        = $clog2(DEPTH),
  parameter int unsigned COMMIT_TIMEOUT = 4096,
  parameter int unsigned FILTER_LEN     = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in,
  input  logic [NUM_TAPS*PHASE_W-1:0] phase_data,
  input  logic                        phase_valid,
  output logic                        phase_ready,
  input  logic [NUM_TAPS-1:0]         tap_enable,
  output logic [NUM_TAPS-1:0]         out,
  output logic                        phase_err,
  output logic                        committed
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(COMMIT_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMMIT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  shadow_q [NUM_TAPS];
  logic [IDX_W-1:0]  shadow_d [NUM_TAPS];
  logic [IDX_W-1:0]  active_q [NUM_TAPS];
  logic [IDX_W-1:0]  active_d [NUM_TAPS];
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              committed_q, committed_d;
  logic [PHASE_W-1:0] fld;

  logic              in_s;
  logic [DEPTH-1:0]  line_q;
  logic [NUM_TAPS-1:0] out_q;
  logic              rise;

  // Input conditioning
`ifdef DELAY_LINE_FILTER_EN
  logic flt_q;
  if (FILTER_LEN <= 1) begin : g_flt1
    always_ff @(posedge clock) begin
      if (reset) flt_q <= 1'b0;
      else       flt_q <= in;
    end
  end else begin : g_fltn
    localparam int unsigned HW = FILTER_LEN - 1;
    logic [HW-1:0] hist_q;
    logic          stable;
    // current sample plus the last HW samples all agree
    assign stable = in ? (&hist_q) : ~(|hist_q);
    always_ff @(posedge clock) begin
      if (reset) begin
        hist_q <= '0;
        flt_q  <= 1'b0;
      end else begin
        hist_q <= HW'({hist_q, in});
        if (stable) flt_q <= in;
      end
    end
  end
  assign in_s = flt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^(32'(FILTER_LEN));
  assign in_s = in;
`endif

  // Delay line and tap selection
  always_ff @(posedge clock) begin
    if (reset) begin
      line_q <= '0;
      out_q  <= '0;
    end else begin
      line_q <= {line_q[DEPTH-2:0], in_s};
      for (int i = 0; i < NUM_TAPS; i++) begin
        out_q[i] <= tap_enable[i] & line_q[active_q[i]];
      end
    end
  end

  // Rising edge currently at the head of the line
  assign rise = line_q[0] & ~line_q[1];

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      committed_q <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      committed_q <= committed_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  // FSM next state: accept, wait for edge/timeout, commit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    shadow_d = shadow_q;
    active_d = active_q;
    fld      = '0;
    case (state_q)
      IDLE: begin
        // ready is high in IDLE, so valid alone marks a transfer
        if (phase_valid) begin
          state_d = PENDING;
          cnt_d   = '0;
          for (int i = 0; i < NUM_TAPS; i++) begin
            fld = phase_data[i*PHASE_W +: PHASE_W];
            if (32'(fld) >= DEPTH) begin
              shadow_d[i] = MAX_IDX;
              err_d       = 1'b1;
            end else begin
              shadow_d[i] = IDX_W'(fld);
            end
          end
        end
      end
      PENDING: begin
        if (rise || (cnt_q == CNT_LAST)) begin
          state_d  = COMMIT;
          active_d = shadow_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d     = (state_d == IDLE);
    committed_d = (state_d == COMMIT);
  end

  assign phase_ready = ready_q;
  assign committed   = committed_q;
  assign phase_err   = err_q;
  assign out         = out_q;

endmodule
